// File: rtl/prescaled_counter.sv
// rtl/prescaled_counter.sv - up/down counter with prescaler, compare-match status and debug halt
// Optional PRESCALED_COUNTER_AUTO_RELOAD_EN adds auto_reload: a match reloads load_val (periodic mode).
module prescaled_counter #(
    parameter int CNT_W = 64,
    parameter int DIV_W = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             timer_en,
    input  logic             div_en,
    input  logic [DIV_W-1:0] clk_div,
    input  logic             halt_req,
    input  logic             dir,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic [CNT_W-1:0] cmp_val,
    input  logic             int_en,
    input  logic             int_clr,
`ifdef PRESCALED_COUNTER_AUTO_RELOAD_EN
    input  logic             auto_reload,
`endif
    output logic [CNT_W-1:0] cnt,
    output logic             int_st,
    output logic             int_o,
    output logic             halt_ack
);

    logic [DIV_W-1:0] presc;
    logic             active;
    logic             tick;
    logic             match;
    logic             reload_hit;

    // Load pre-empts everything, so neither a tick nor a match can occur in a load cycle.
    assign active = !load && timer_en && !halt_req;
    // >= (not ==) lets a lowered clk_div end the current period at once.
    assign tick   = active && (!div_en || (presc >= clk_div));
    assign match  = tick && (cnt == cmp_val);

`ifdef PRESCALED_COUNTER_AUTO_RELOAD_EN
    assign reload_hit = match && auto_reload;
`else
    assign reload_hit = 1'b0;
`endif

    assign int_o = int_st && int_en;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt      <= '0;
            presc    <= '0;
            int_st   <= 1'b0;
            halt_ack <= 1'b0;
        end else begin
            halt_ack <= halt_req && timer_en;

            if (match) begin
                int_st <= 1'b1;
            end else if (int_clr) begin
                int_st <= 1'b0;
            end

            if (load) begin
                cnt   <= load_val;
                presc <= '0;
            end else if (!timer_en) begin
                presc <= '0;
            end else if (!halt_req) begin
                if (!div_en || tick) begin
                    presc <= '0;
                end else begin
                    presc <= presc + DIV_W'(1);
                end

                if (reload_hit) begin
                    cnt <= load_val;
                end else if (tick) begin
                    cnt <= dir ? (cnt - CNT_W'(1)) : (cnt + CNT_W'(1));
                end
            end
        end
    end

endmodule

// File: doc/prescaled_counter.md
PRESCALED_COUNTER -- requirements
Module: prescaled_counter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 64, which sets the counter width in bits (legal range 8..64).
REQ-002 The block SHALL have parameter DIV_W, default 8, which sets the prescaler width in bits (legal range 1..16).
REQ-003 sys_clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 sys_rst_n  in  1  reset, asynchronous and active-low.
REQ-005 timer_en  in  1  counting enable.
REQ-006 div_en  in  1  1 = prescaled ticks; 0 = one tick every cycle.
REQ-007 clk_div  in  DIV_W  prescaler terminal value; tick period is clk_div+1 cycles.
REQ-008 halt_req  in  1  debug halt; freezes the counter and the prescaler.
REQ-009 dir  in  1  0 = count up, 1 = count down.
REQ-010 load  in  1  one-cycle strobe that loads load_val into the counter.
REQ-011 load_val  in  CNT_W  load and reload value.
REQ-012 cmp_val  in  CNT_W  compare value.
REQ-013 int_en  in  1  interrupt enable.
REQ-014 int_clr  in  1  one-cycle strobe that clears int_st.
REQ-015 cnt  out  CNT_W  counter value, registered.
REQ-016 int_st  out  1  sticky compare-match status, registered.
REQ-017 int_o  out  1  interrupt output, equal to int_st AND int_en (combinational).
REQ-018 halt_ack  out  1  halt acknowledge, registered.

Function
REQ-019 Priority SHALL be, highest first: load, then !timer_en, then halt_req, then tick.
REQ-020 load=1 SHALL set cnt<=load_val and the prescaler<=0 on the next edge, regardless of timer_en or halt_req; no match event SHALL occur that cycle.
REQ-021 timer_en=0 (without load) SHALL hold cnt and clear the prescaler to 0.
REQ-022 timer_en=1 with halt_req=1 SHALL hold both cnt and the prescaler, including when the prescaler is at its terminal value.
REQ-023 The tick SHALL be generated as follows: div_en=0 gives tick=1 every enabled, unhalted cycle; div_en=1 gives tick=1 when prescaler>=clk_div, at which point the prescaler<=0, otherwise the prescaler increments.
REQ-024 The >= comparison SHALL make a clk_div decrease below the current prescaler value end the period immediately, without waiting for prescaler wrap.
REQ-025 clk_div=0 with div_en=1 SHALL produce a tick every cycle.
REQ-026 On a tick, cnt SHALL step by +1 (dir=0) or -1 (dir=1), modulo 2^CNT_W: all-ones+1 wraps to 0, and 0-1 wraps to all-ones.
REQ-027 A match event SHALL be defined as a tick in a cycle where cnt==cmp_val.
REQ-028 A match event SHALL set int_st on the next edge, with one-cycle latency.
REQ-029 int_clr=1 SHALL clear int_st; if a match event occurs in the same cycle, the set SHALL win.
REQ-030 int_st SHALL update independently of int_en; int_en SHALL gate int_o only.
REQ-031 halt_ack SHALL be set on the edge after a cycle with halt_req=1 and timer_en=1, and SHALL be cleared on the edge after either input is low.
REQ-032 A dir change SHALL take effect on the next tick, with no extra step or lost step.

Reset
REQ-033 sys_rst_n=0 SHALL asynchronously force cnt=0, prescaler=0, int_st=0 and halt_ack=0; int_o SHALL therefore be 0.
REQ-034 Reset deassertion SHALL be sampled on sys_clk; the first tick SHALL be possible on the first edge after deassertion with timer_en=1.
REQ-035 Reset asserted mid-count or mid-prescale SHALL discard all state; no match event SHALL be generated.

Configuration
REQ-036 Macro PRESCALED_COUNTER_AUTO_RELOAD_EN, when defined, SHALL add input port auto_reload (1 bit).
REQ-037 With the macro defined and auto_reload=1, a match event SHALL load cnt<=load_val instead of stepping, giving periodic mode; int_st SHALL still be set.
REQ-038 With the macro defined and auto_reload=0, the block SHALL behave exactly as in the macro-undefined build.
REQ-039 With the macro undefined, the auto_reload port and the reload path SHALL be absent; a match SHALL only set int_st, and cnt SHALL continue stepping.

Verification
REQ-040 Prescale: reset, CNT_W=64, div_en=1, clk_div=3, timer_en=1 for 20 cycles -> cnt=5, increments every 4th cycle.
REQ-041 Halt at terminal: clk_div=3, prescaler=3, assert halt_req for 5 cycles -> cnt and prescaler frozen, halt_ack=1 from the 2nd cycle; after release, cnt+1 on the next edge.
REQ-042 Wrap: load_val=0xFFFF_FFFF_FFFF_FFFE, div_en=0, dir=0, 3 ticks -> cnt 0x...FF, 0x0, 0x1; then dir=1, 2 ticks -> 0x0, 0x...FF.
REQ-043 Match and clear: cmp_val=10, load_val=8, int_en=1 -> int_st=1 and int_o=1 one cycle after the tick at cnt=10; int_clr coincident with a second match (dir=1 back to 10) -> int_st stays 1.
REQ-044 Auto-reload (macro defined): load_val=2, cmp_val=5, auto_reload=1, div_en=0 -> cnt sequence 2,3,4,5,2,3,...; int_st=1 after the first reload.
REQ-045 Reset mid-count: assert sys_rst_n=0 asynchronously between edges at cnt=7, int_st=1 -> cnt=0 and int_st=0 immediately, without waiting for an edge.
